// File: rtl/spc_wr_arbiter.sv
// Purpose: round-robin arbiter/sequencer for the special register file user write port.
// Latency: req sampled at edge N -> gnt and wr_usr_enable high in cycle N+1; at most one write per 3 cycles.
// Backpressure: requesters hold req/addr/data until gnt; losing requesters simply keep waiting.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   req/req_addr/req_data - per-requester level request, 3-bit target address, 32-bit data (packed by index)
//   gnt/err             - one-cycle completion pulse to the winner; err marks a blocked protected write
//   wr_usr_enable/write_usr_addr/usr_data - register file user write port
//   busy                - high while a transaction is in flight (state != IDLE)
module spc_wr_arbiter #(
  parameter int          NREQ         = 4,
  parameter logic [7:0]  PROTECT_MASK = 8'b0100_0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [3*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    err,
  output logic               wr_usr_enable,
  output logic [2:0]         write_usr_addr,
  output logic [31:0]        usr_data,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   win, win_nxt;
  logic [PW-1:0]   pick;
  logic            found;
  logic [2:0]      sel_addr;
  logic [31:0]     sel_data;
  logic [NREQ-1:0] gnt_nxt, err_nxt;
  logic            wr_nxt, busy_nxt;
  logic [2:0]      addr_nxt;
  logic [31:0]     data_nxt;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NREQ;
    return PW'(s);
  endfunction

  // Walk the offsets from the far end back towards ptr so the last hit,
  // which is the one closest to ptr, wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[rr_idx(ptr, i)]) begin
        found = 1'b1;
        pick  = rr_idx(ptr, i);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == PW'(k)) begin
        sel_addr = req_addr[3*k +: 3];
        sel_data = req_data[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win;
    gnt_nxt   = '0;
    err_nxt   = '0;
    wr_nxt    = 1'b0;
    addr_nxt  = write_usr_addr;  // address/data hold their last values outside ISSUE
    data_nxt  = usr_data;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = ISSUE;
          win_nxt       = pick;
          addr_nxt      = sel_addr;
          data_nxt      = sel_data;
          gnt_nxt[pick] = 1'b1;
          // A protected target still completes the handshake, just without the write.
          if (PROTECT_MASK[sel_addr]) err_nxt[pick] = 1'b1;
          else                        wr_nxt        = 1'b1;
        end
      end
      ISSUE: begin
        ptr_nxt   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        state_nxt = RECOVER;
      end
      RECOVER: begin
        // Requests are ignored here so a winner dropping req late is not re-granted.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ptr            <= '0;
      win            <= '0;
      gnt            <= '0;
      err            <= '0;
      wr_usr_enable  <= 1'b0;
      write_usr_addr <= '0;
      usr_data       <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      ptr            <= ptr_nxt;
      win            <= win_nxt;
      gnt            <= gnt_nxt;
      err            <= err_nxt;
      wr_usr_enable  <= wr_nxt;
      write_usr_addr <= addr_nxt;
      usr_data       <= data_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_spc_wr_arbiter.sv
module tb_spc_wr_arbiter;
  localparam int         NREQ  = 4;
  localparam int         AW    = 3 * NREQ;
  localparam int         DW    = 32 * NREQ;
  localparam logic [7:0] PMASK = 8'b0100_0001;

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_data;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] err;
  logic            wr_usr_enable;
  logic [2:0]      write_usr_addr;
  logic [31:0]     usr_data;
  logic            busy;

  spc_wr_arbiter #(.NREQ(NREQ), .PROTECT_MASK(PMASK)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .gnt            (gnt),
    .err            (err),
    .wr_usr_enable  (wr_usr_enable),
    .write_usr_addr (write_usr_addr),
    .usr_data       (usr_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Register file model fed by the user write port.
  logic [31:0] rf [8] = '{default: '0};
  always @(posedge clk) if (reset && wr_usr_enable) rf[write_usr_addr] <= usr_data;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] err;
    logic            wr;
    logic [2:0]      addr;
    logic [31:0]     data;
  } exp_t;

  exp_t exp_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  bit   auto_drop = 1'b1;
  bit   seen_gnt;
  int   lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Raise requester k and queue the grant the bench expects for it.
  task automatic drive(input int k, input logic [2:0] a, input logic [31:0] d);
    exp_t e;
    req_addr = (req_addr & ~(AW'(3'h7) << (3*k))) | (AW'(a) << (3*k));
    req_data = (req_data & ~(DW'(32'hFFFF_FFFF) << (32*k))) | (DW'(d) << (32*k));
    req      = req | NREQ'(1 << k);
    e.gnt  = NREQ'(1 << k);
    e.err  = PMASK[a] ? e.gnt : '0;
    e.wr   = !PMASK[a];
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock; sample 1 time unit after the edge and score any grant.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (gnt !== '0) begin
      seen_gnt = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 64'(gnt), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("gnt",  64'(gnt), 64'(e.gnt));
        check("err",  64'(err), 64'(e.err));
        check("wr",   64'(wr_usr_enable), 64'(e.wr));
        check("addr", 64'(write_usr_addr), 64'(e.addr));
        check("data", 64'(usr_data), 64'(e.data));
        check("busy_issue", 64'(busy), 64'(1));
      end
      if (auto_drop) req = req & ~gnt;
    end else begin
      check("idle_wr",  64'(wr_usr_enable), 64'(0));
      check("idle_err", 64'(err), 64'(0));
    end
  endtask

  task automatic wait_gnt(input string tag, output int n);
    n = 0;
    seen_gnt = 1'b0;
    while (!seen_gnt && n < 12) begin
      tick();
      n++;
    end
    if (!seen_gnt) check({tag, "_timeout"}, 64'(seen_gnt), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req = '0; req_addr = '0; req_data = '0;
    #1;
    check("rst_gnt",  64'(gnt), 64'(0));
    check("rst_err",  64'(err), 64'(0));
    check("rst_wr",   64'(wr_usr_enable), 64'(0));
    check("rst_addr", 64'(write_usr_addr), 64'(0));
    check("rst_data", 64'(usr_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick(); tick();

    // Basic write, latency and busy profile.
    drive(0, 3'd3, 32'hDEAD_BEEF);
    wait_gnt("basic", lat);
    check("basic_lat", 64'(lat), 64'(1));
    tick();
    check("basic_busy_rec", 64'(busy), 64'(1));
    tick();
    check("basic_busy_idle", 64'(busy), 64'(0));

    // Reset asserted during ISSUE aborts the write.
    drive(2, 3'd5, 32'h5555_0005);
    wait_gnt("abort", lat);
    check("abort_lat", 64'(lat), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("abort_gnt",  64'(gnt), 64'(0));
    check("abort_wr",   64'(wr_usr_enable), 64'(0));
    check("abort_err",  64'(err), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_addr", 64'(write_usr_addr), 64'(0));
    check("abort_data", 64'(usr_data), 64'(0));
    req = '0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    tick();

    // Pointer is back at 0: 0 must beat 3.
    drive(0, 3'd1, 32'h1111_0000);
    drive(3, 3'd7, 32'h7777_0003);
    wait_gnt("ptr0_a", lat);
    check("ptr0_a_lat", 64'(lat), 64'(1));
    wait_gnt("ptr0_b", lat);
    check("ptr0_b_gap", 64'(lat), 64'(3));
    tick(); tick();

    // All four requesting: order 0,1,2,3 with 3-cycle spacing.
    drive(0, 3'd1, 32'hA000_0000);
    drive(1, 3'd2, 32'hA000_0001);
    drive(2, 3'd3, 32'hA000_0002);
    drive(3, 3'd7, 32'hA000_0003);
    for (int k = 0; k < NREQ; k++) begin
      wait_gnt($sformatf("rr%0d", k), lat);
      check($sformatf("rr%0d_gap", k), 64'(lat), (k == 0) ? 64'(1) : 64'(3));
    end
    tick(); tick();

    // Protected targets: PC (6) and ZR (0) blocked, 4 written.
    drive(1, 3'd6, 32'h0000_0100);
    wait_gnt("prot_pc", lat);
    tick(); tick();
    drive(0, 3'd0, 32'h0000_0200);
    wait_gnt("prot_zr", lat);
    tick(); tick();
    drive(2, 3'd4, 32'h0000_0400);
    wait_gnt("prot_ok", lat);
    tick(); tick();
    check("pc_unchanged", 64'(rf[6]), 64'(0));
    check("zr_unchanged", 64'(rf[0]), 64'(0));
    check("r4_written",   64'(rf[4]), 64'(32'h0000_0400));

    // Pointer wrap: after grant to 2, ptr=3, so 0 goes before 2.
    drive(0, 3'd1, 32'h0000_0A0A);
    drive(2, 3'd3, 32'h0000_0C0C);
    wait_gnt("wrap_a", lat);
    check("wrap_a_lat", 64'(lat), 64'(1));
    wait_gnt("wrap_b", lat);
    check("wrap_b_gap", 64'(lat), 64'(3));
    tick(); tick();

    // Stale request held one cycle past gnt must not produce a second write.
    auto_drop = 1'b0;
    drive(3, 3'd2, 32'h0000_5A5A);
    wait_gnt("stale", lat);
    check("stale_lat", 64'(lat), 64'(1));
    tick();
    check("stale_busy_rec", 64'(busy), 64'(1));
    tick();
    check("stale_busy_idle", 64'(busy), 64'(0));
    req = '0;
    auto_drop = 1'b1;
    repeat (4) tick();
    check("stale_busy_end", 64'(busy), 64'(0));

    check("q_empty",      64'(exp_q.size()), 64'(0));
    check("r5_aborted",   64'(rf[5]), 64'(0));
    check("r3_final",     64'(rf[3]), 64'(32'h0000_0C0C));
    check("r2_final",     64'(rf[2]), 64'(32'h0000_5A5A));
    check("r7_final",     64'(rf[7]), 64'(32'hA000_0003));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
